// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI FSM states and {cpol,cpha} mode constants for master and slave
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_e;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: CLK_DIV half-period divider producing SCLK level and leading/trailing edge strobes
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic xfer,
  input  logic cpol,
  output logic tick,
  output logic lead_edge,
  output logic trail_edge,
  output logic sclk
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic sclk_q, sclk_d;
  always_comb begin
    tick = run && div_q == DW'(CLK_DIV - 1);
    lead_edge = tick && xfer && sclk_q == cpol;
    trail_edge = tick && xfer && sclk_q != cpol;
    div_d = !run || tick ? '0 : div_q + DW'(1);
    sclk_d = !run ? cpol : (xfer && tick) ? ~sclk_q : sclk_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      div_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sclk_q <= sclk_d;
    end
  assign sclk = sclk_q;
endmodule

// File: rtl/spi_master.sv
// spi_master: single-word SPI master, modes 0-3, programmable SCLK divider and bit order
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);
  localparam int EW = $clog2(2 * DATA_WIDTH);
  state_e state_q, state_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic busy_q, busy_d, rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic [EW-1:0] edge_q, edge_d;
  logic tick, lead_edge, trail_edge, accept, last, emit, sample, done;
  function automatic logic head(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w, input logic b);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
  endfunction
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk(clk),
    .rst(rst),
    .run(state_q != IDLE),
    .xfer(state_q == XFER),
    .cpol(state_q == IDLE ? cpol : cpol_q),
    .tick(tick),
    .lead_edge(lead_edge),
    .trail_edge(trail_edge),
    .sclk(sclk)
  );
  // cpha=0 presents its first bit at acceptance, so only the later bits are emitted on edges
  always_comb begin
    accept = state_q == IDLE && start;
    last = edge_q == EW'(2 * DATA_WIDTH - 1);
    done = state_q == TRAIL && tick;
    emit = state_q == XFER && (cpha_q ? lead_edge : trail_edge && !last);
    sample = state_q == XFER && (cpha_q ? trail_edge : lead_edge);
    state_d = accept ? LEAD : !tick ? state_q : state_q == LEAD ? XFER :
              state_q == TRAIL ? IDLE : last ? TRAIL : state_q;
    cpol_d = accept ? cpol : cpol_q;
    cpha_d = accept ? cpha : cpha_q;
    tx_d = accept ? (cpha ? tx_data : shift_in(tx_data, 1'b0)) : emit ? shift_in(tx_q, 1'b0) : tx_q;
    mosi_d = accept ? !cpha && head(tx_data) : done ? 1'b0 : emit ? head(tx_q) : mosi_q;
    rx_d = accept ? '0 : sample ? shift_in(rx_q, miso) : rx_q;
    edge_d = state_q != XFER || (tick && last) ? '0 : edge_q + EW'(tick);
    cs_n_d = accept ? 1'b0 : done ? 1'b1 : cs_n_q;
    busy_d = accept ? 1'b1 : done ? 1'b0 : busy_q;
    rx_valid_d = done;
    rx_data_d = done ? rx_q : rx_data_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      tx_q <= '0;
      rx_q <= '0;
      edge_q <= '0;
      mosi_q <= 1'b0;
      cs_n_q <= 1'b1;
      busy_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q <= state_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      edge_q <= edge_d;
      mosi_q <= mosi_d;
      cs_n_q <= cs_n_d;
      busy_q <= busy_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q <= rx_data_d;
    end
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;
  assign busy = busy_q;
  assign rx_valid = rx_valid_q;
  assign rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: two masters (MSB-first div 2, LSB-first div 3) against a behavioural SPI slave
module tb_spi_master;
  import spi_pkg::*;
  localparam int DIV0 = 2;
  localparam int DIV1 = 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0, miso = 1'b0, sel = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic start0, start1, sclk0, sclk1, cs0, cs1, mosi0, mosi1, rxv0, rxv1, busy0, busy1;
  logic [7:0] rxd0, rxd1, rxd_m;
  logic sclk_m, cs_m, mosi_m, rxv_m, busy_m;
  int n_vec = 0, n_err = 0;
  logic s_cpol = 1'b0, s_cpha = 1'b0, s_cs_prev = 1'b1, s_sclk_prev = 1'b0;
  logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
  int s_in = 0, s_out = 0, s_edges = 0;
  typedef struct {
    logic       s;
    logic [1:0] mode;
    logic [7:0] mtx, stx, exp_m, exp_s;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign sclk_m = sel ? sclk1 : sclk0;
  assign cs_m   = sel ? cs1 : cs0;
  assign mosi_m = sel ? mosi1 : mosi0;
  assign rxv_m  = sel ? rxv1 : rxv0;
  assign busy_m = sel ? busy1 : busy0;
  assign rxd_m  = sel ? rxd1 : rxd0;

  spi_master #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .CLK_DIV(DIV0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
    .miso(miso), .sclk(sclk0), .cs_n(cs0), .mosi(mosi0), .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0));
  spi_master #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .CLK_DIV(DIV1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
    .miso(miso), .sclk(sclk1), .cs_n(cs1), .mosi(mosi1), .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1));

  // bit k of a word goes out k-th: MSB-first for dut0, LSB-first for dut1
  function automatic logic [2:0] pos(input int k);
    return sel ? 3'(k) : 3'(7 - k);
  endfunction

  function automatic int exp_len(input logic s);
    return (2 * 8 + 2) * (s ? DIV1 : DIV0);
  endfunction

  // behavioural slave: drives on the non-sampling edge, samples mosi on the sampling edge
  always @(cs_m or sclk_m) begin
    if (cs_m === 1'b0 && s_cs_prev !== 1'b0) begin
      s_in = 0;
      s_out = s_cpha ? 0 : 1;
      s_edges = 0;
      s_rx = 8'h00;
      miso = s_cpha ? 1'b0 : s_tx[pos(0)];
    end else if (cs_m === 1'b0 && sclk_m !== s_sclk_prev) begin
      s_edges++;
      if ((sclk_m != s_cpol) != s_cpha) begin
        if (s_in < 8) s_rx[pos(s_in)] = mosi_m;
        s_in++;
      end else if (s_out < 8) begin
        miso = s_tx[pos(s_out)];
        s_out++;
      end
    end
    s_cs_prev = cs_m;
    s_sclk_prev = sclk_m;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic s, input logic [1:0] mode, input logic [7:0] mtx, input logic [7:0] stx,
                      input logic [7:0] exp_m, input logic [7:0] exp_s, input bit scramble);
    int lowc, bad;
    sel = s;
    cpol = mode[1];
    cpha = mode[0];
    s_cpol = mode[1];
    s_cpha = mode[0];
    s_tx = stx;
    tx_data = mtx;
    repeat (2) @(negedge clk);
    chk("sclk_idle_pre", 32'(sclk_m), 32'(mode[1]));
    chk("cs_idle_pre", 32'(cs_m), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lowc = 0;
    bad = 0;
    while (cs_m === 1'b0 && lowc < 1000) begin
      lowc++;
      if (busy_m !== 1'b1 || rxv_m !== 1'b0) bad++;
      if (scramble) begin
        cpol = 1'($urandom);
        cpha = 1'($urandom);
        tx_data = 8'($urandom);
        start = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("cs_low_cycles", 32'(lowc), 32'(exp_len(s)));
    chk("busy_during_xfer", 32'(bad), 32'd0);
    chk("rx_valid_pulse", 32'(rxv_m), 32'd1);
    chk("master_rx", 32'(rxd_m), 32'(exp_m));
    chk("slave_rx", 32'(s_rx), 32'(exp_s));
    chk("sclk_edges", 32'(s_edges), 32'd16);
    chk("busy_end", 32'(busy_m), 32'd0);
    chk("sclk_idle_post", 32'(sclk_m), 32'(mode[1]));
    chk("mosi_idle", 32'(mosi_m), 32'd0);
    @(negedge clk);
    chk("rx_valid_one_cycle", 32'(rxv_m), 32'd0);
    @(negedge clk);
    chk("no_queued_start", 32'(cs_m), 32'd1);
  endtask

  initial begin
    int lowc, gap, low2, w;
    logic [7:0] a, b;
    logic       rs;
    tbl[0] = '{1'b0, MODE0, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
    tbl[1] = '{1'b0, MODE1, 8'h55, 8'hF0, 8'hF0, 8'h55};
    tbl[2] = '{1'b0, MODE2, 8'h99, 8'h12, 8'h12, 8'h99};
    tbl[3] = '{1'b0, MODE3, 8'h42, 8'h77, 8'h77, 8'h42};
    tbl[4] = '{1'b1, MODE0, 8'h01, 8'h80, 8'h80, 8'h01};
    tbl[5] = '{1'b1, MODE3, 8'hB4, 8'h2D, 8'h2D, 8'hB4};
    tbl[6] = '{1'b1, MODE1, 8'hE7, 8'h18, 8'h18, 8'hE7};
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'({cs1, cs0}), 32'h3);
    chk("rst_sclk", 32'({sclk1, sclk0}), 32'h0);
    chk("rst_mosi", 32'({mosi1, mosi0}), 32'h0);
    chk("rst_rx_data", 32'({rxd1, rxd0}), 32'h0);
    chk("rst_rx_valid", 32'({rxv1, rxv0}), 32'h0);
    chk("rst_busy", 32'({busy1, busy0}), 32'h0);
    rst = 1'b0;
    cpol = 1'b1;
    #1 chk("idle_sclk_latency", 32'(sclk0), 32'd0);
    @(negedge clk);
    chk("idle_sclk_follow_hi", 32'(sclk0), 32'd1);
    chk("idle_mosi", 32'(mosi0), 32'd0);
    cpol = 1'b0;
    @(negedge clk);
    chk("idle_sclk_follow_lo", 32'(sclk0), 32'd0);
    for (int i = 0; i < 7; i++)
      xfer(tbl[i].s, tbl[i].mode, tbl[i].mtx, tbl[i].stx, tbl[i].exp_m, tbl[i].exp_s, 1'b0);
    sel = 1'b0;
    cpol = 1'b0;
    cpha = 1'b0;
    s_cpol = 1'b0;
    s_cpha = 1'b0;
    s_tx = 8'h69;
    tx_data = 8'h96;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    lowc = 0;
    while (cs_m === 1'b0 && lowc < 1000) begin
      lowc++;
      @(negedge clk);
    end
    chk("b2b_len1", 32'(lowc), 32'd36);
    chk("b2b_rxv", 32'(rxv_m), 32'd1);
    chk("b2b_rxd1", 32'(rxd_m), 32'h69);
    chk("b2b_srx1", 32'(s_rx), 32'h96);
    tx_data = 8'h3A;
    gap = 0;
    while (cs_m === 1'b1 && gap < 100) begin
      gap++;
      @(negedge clk);
    end
    chk("b2b_gap", 32'(gap), 32'd1);
    start = 1'b0;
    low2 = 0;
    while (cs_m === 1'b0 && low2 < 1000) begin
      low2++;
      @(negedge clk);
    end
    chk("b2b_len2", 32'(low2), 32'd36);
    chk("b2b_rxd2", 32'(rxd_m), 32'h69);
    chk("b2b_srx2", 32'(s_rx), 32'h3A);
    @(negedge clk);
    chk("b2b_stop", 32'(cs_m), 32'd1);
    s_tx = 8'hFF;
    tx_data = 8'h0F;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (s_in < 4 && w < 500) begin
      w++;
      @(negedge clk);
    end
    chk("abort_at_bit4", 32'(s_in), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", 32'(cs_m), 32'd1);
    chk("abort_sclk", 32'(sclk_m), 32'd0);
    chk("abort_busy", 32'(busy_m), 32'd0);
    chk("abort_rx_valid", 32'(rxv_m), 32'd0);
    chk("abort_mosi", 32'(mosi_m), 32'd0);
    chk("abort_rx_data", 32'(rxd_m), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_rx_valid", 32'(rxv_m), 32'd0);
    chk("abort_stays_idle", 32'(cs_m), 32'd1);
    xfer(1'b0, MODE0, 8'hC3, 8'h5E, 8'h5E, 8'hC3, 1'b0);
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      rs = 1'($urandom);
      xfer(rs, 2'($urandom_range(0, 3)), a, b, b, a, 1'b1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
